flash_loader: RTL and testbench

//  SPI-flash boot loader: on start, issues READ (0x03) + 24-bit address to the serial flash,

---
 rtl/flash_loader_pkg.sv | 33 +++
 rtl/flash_loader_spi_shifter.sv | 69 ++++++
 rtl/flash_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_flash_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the SPI-flash boot loader.
package flash_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_WAIT_RAM,
    ST_FINISH
  } state_e;

  localparam logic [7:0] FlashCmdRead = 8'h03;

  localparam logic [1:0] RamWriteNone = 2'b00;
  localparam logic [1:0] RamWriteWord = 2'b11;
  localparam logic [2:0] RamReadNone  = 3'b000;

  // Address bytes go out most significant first: idx 0 is bits [23:16].
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = addr[23:16];
      2'd1:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_loader_spi_shifter.sv
// Mode-0 SPI byte engine. One bit takes two clk cycles: phase A holds
// sclk low with mosi presenting the bit, phase B holds sclk high. miso is
// captured on the clk edge that raises sclk. A load on the cycle that
// finishes a byte chains the next byte with no gap on the wire.
module spi_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] tx_byte_i,
  input  logic       run_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       byte_done_o,
  output logic [7:0] rx_byte_o
);

  logic       active_q;
  logic       phase_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] tx_q;
  logic [7:0] rx_q;
  logic       sclk_q;
  logic       mosi_q;

  // Last phase-B cycle of the eighth bit; rx_q already holds all 8 bits.
  assign byte_done_o = active_q && run_i && phase_q && (bit_cnt_q == 3'd7);
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign rx_byte_o   = rx_q;

  // Bit engine: load a byte, then alternate phases while run_i is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else if (load_i) begin
      active_q  <= 1'b1;
      phase_q   <= 1'b0;
      bit_cnt_q <= 3'd0;
      tx_q      <= tx_byte_i;
      sclk_q    <= 1'b0;
      mosi_q    <= tx_byte_i[7];
    end else if (active_q && run_i) begin
      if (!phase_q) begin
        sclk_q  <= 1'b1;
        rx_q    <= {rx_q[6:0], miso_i};
        phase_q <= 1'b1;
      end else begin
        sclk_q  <= 1'b0;
        phase_q <= 1'b0;
        if (bit_cnt_q == 3'd7) begin
          active_q <= 1'b0;
          mosi_q   <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          tx_q      <= {tx_q[6:0], 1'b0};
          mosi_q    <= tx_q[6];
        end
      end
    end
  end

endmodule

// File: rtl/flash_loader.sv
// SPI-flash boot loader: sends READ + 24-bit address, streams bytes in,
// packs them little-endian into 32-bit words and writes each word through
// the ramio write port. The SPI stream stalls (sclk low) while a word is
// being written, so no flash bit is lost.
//
// ramio handshake: a request is raised only after ramio_busy has been seen
// low; ramio_enable is a single-cycle strobe with write_type=Word, and the
// loader then skips one cycle and waits for ramio_busy low before resuming.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned StartupWaitCycles      = 0,
  parameter int unsigned FlashTransferByteCount = 2048,
  parameter logic [23:0] FlashReadAddress       = 24'h000000,
  parameter logic [31:0] RamStartAddress        = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [2:0]  ramio_read_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy
);

  localparam int ByteCntW = $clog2(FlashTransferByteCount + 1);
  localparam int WaitCntW = (StartupWaitCycles > 1) ? $clog2(StartupWaitCycles) : 1;

  localparam logic [ByteCntW-1:0] ByteOne   = 1;
  localparam logic [ByteCntW-1:0] ByteLast  = ByteCntW'(FlashTransferByteCount - 1);
  localparam logic [ByteCntW-1:0] ByteTotal = ByteCntW'(FlashTransferByteCount);
  localparam logic [WaitCntW-1:0] WaitOne   = 1;
  localparam logic [WaitCntW-1:0] WaitLast  =
    (StartupWaitCycles > 0) ? WaitCntW'(StartupWaitCycles - 1) : '0;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                cs_n_q;
  logic                en_q;
  logic [1:0]          wtype_q;
  logic [31:0]         ram_addr_out_q;
  logic [31:0]         ram_data_out_q;
  logic [31:0]         ram_addr_q;
  logic [31:0]         word_q;
  logic [31:0]         word_d;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic [1:0]          lane_q;
  logic [1:0]          addr_idx_q;
  logic [WaitCntW-1:0] wait_cnt_q;
  logic                skip_q;

  logic       sh_load;
  logic [7:0] sh_tx;
  logic       sh_run;
  logic       sh_done;
  logic [7:0] sh_rx;
  logic       last_byte;
  logic       word_end;
  logic       all_bytes;

  assign sh_run    = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_READ);
  assign last_byte = (byte_cnt_q == ByteLast);
  assign word_end  = (lane_q == 2'd3) || last_byte;
  assign all_bytes = (byte_cnt_q == ByteTotal);

  spi_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (sh_load),
    .tx_byte_i   (sh_tx),
    .run_i       (sh_run),
    .miso_i      (flash_miso),
    .sclk_o      (flash_clk),
    .mosi_o      (flash_mosi),
    .byte_done_o (sh_done),
    .rx_byte_o   (sh_rx)
  );

  // Merge the received byte into its little-endian lane of the word.
  always_comb begin
    word_d = word_q;
    word_d[8*lane_q +: 8] = sh_rx;
  end

  // Pick the next byte for the shifter; loading at byte end keeps bits back-to-back.
  always_comb begin
    sh_load = 1'b0;
    sh_tx   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (start && (StartupWaitCycles == 0)) begin
          sh_load = 1'b1;
          sh_tx   = FlashCmdRead;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WaitLast) begin
          sh_load = 1'b1;
          sh_tx   = FlashCmdRead;
        end
      end
      ST_CMD: begin
        if (sh_done) begin
          sh_load = 1'b1;
          sh_tx   = addr_byte(FlashReadAddress, 2'd0);
        end
      end
      ST_ADDR: begin
        if (sh_done) begin
          sh_load = 1'b1;
          sh_tx   = (addr_idx_q == 2'd2) ? 8'h00 : addr_byte(FlashReadAddress, addr_idx_q + 2'd1);
        end
      end
      ST_READ: begin
        if (sh_done && !word_end) begin
          sh_load = 1'b1;
        end
      end
      ST_WAIT_RAM: begin
        if (!skip_q && !ramio_busy && !all_bytes) begin
          sh_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Loader sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      en_q           <= 1'b0;
      wtype_q        <= RamWriteNone;
      ram_addr_out_q <= 32'h0;
      ram_data_out_q <= 32'h0;
      ram_addr_q     <= 32'h0;
      word_q         <= 32'h0;
      byte_cnt_q     <= '0;
      lane_q         <= 2'd0;
      addr_idx_q     <= 2'd0;
      wait_cnt_q     <= '0;
      skip_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q     <= 1'b1;
            byte_cnt_q <= '0;
            lane_q     <= 2'd0;
            word_q     <= 32'h0;
            ram_addr_q <= RamStartAddress;
            wait_cnt_q <= '0;
            if (StartupWaitCycles == 0) begin
              cs_n_q  <= 1'b0;
              state_q <= ST_CMD;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == WaitLast) begin
            cs_n_q  <= 1'b0;
            state_q <= ST_CMD;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitOne;
          end
        end
        ST_CMD: begin
          if (sh_done) begin
            addr_idx_q <= 2'd0;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sh_done) begin
            if (addr_idx_q == 2'd2) begin
              state_q <= ST_READ;
            end else begin
              addr_idx_q <= addr_idx_q + 2'd1;
            end
          end
        end
        ST_READ: begin
          if (sh_done) begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + ByteOne;
            lane_q     <= lane_q + 2'd1;
            if (word_end) begin
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (!ramio_busy) begin
            en_q           <= 1'b1;
            wtype_q        <= RamWriteWord;
            ram_addr_out_q <= ram_addr_q;
            ram_data_out_q <= word_q;
            word_q         <= 32'h0;
            ram_addr_q     <= ram_addr_q + 32'd4;
            skip_q         <= 1'b1;
            state_q        <= ST_WAIT_RAM;
          end
        end
        ST_WAIT_RAM: begin
          en_q    <= 1'b0;
          wtype_q <= RamWriteNone;
          if (skip_q) begin
            skip_q <= 1'b0;
          end else if (!ramio_busy) begin
            if (all_bytes) begin
              cs_n_q  <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign flash_cs_n       = cs_n_q;
  assign ramio_enable     = en_q;
  assign ramio_write_type = wtype_q;
  assign ramio_read_type  = RamReadNone;
  assign ramio_address    = ram_addr_out_q;
  assign ramio_data_in    = ram_data_out_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: two instances (8 bytes, no startup wait, address 0;
// 6 bytes, 3-cycle wait, non-zero flash and RAM addresses) each talking to a
// behavioural flash and a ramio write monitor.
module tb_flash_loader;
  import flash_loader_pkg::*;

  localparam int          N0  = 8;
  localparam int          N1  = 6;
  localparam int          W1  = 3;
  localparam logic [23:0] FA1 = 24'h123456;
  localparam logic [31:0] RB1 = 32'h00000100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start = '0;
  logic [1:0]  busy, done, fclk, mosi, cs_n, en;
  logic [1:0]  miso  = '0;
  logic [1:0]  rbusy = '0;
  logic [1:0]  wtype [2];
  logic [2:0]  rtype [2];
  logic [31:0] raddr [2];
  logic [31:0] rdata [2];

  flash_loader #(
    .StartupWaitCycles(0), .FlashTransferByteCount(N0),
    .FlashReadAddress(24'h000000), .RamStartAddress(32'h0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .flash_clk(fclk[0]), .flash_mosi(mosi[0]), .flash_miso(miso[0]), .flash_cs_n(cs_n[0]),
    .ramio_enable(en[0]), .ramio_write_type(wtype[0]), .ramio_read_type(rtype[0]),
    .ramio_address(raddr[0]), .ramio_data_in(rdata[0]), .ramio_busy(rbusy[0])
  );

  flash_loader #(
    .StartupWaitCycles(W1), .FlashTransferByteCount(N1),
    .FlashReadAddress(FA1), .RamStartAddress(RB1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .flash_clk(fclk[1]), .flash_mosi(mosi[1]), .flash_miso(miso[1]), .flash_cs_n(cs_n[1]),
    .ramio_enable(en[1]), .ramio_write_type(wtype[1]), .ramio_read_type(rtype[1]),
    .ramio_address(raddr[1]), .ramio_data_in(rdata[1]), .ramio_busy(rbusy[1])
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];

  logic [7:0]  fmem [2][16];
  logic [7:0]  fixed_bytes [8] = '{8'h37, 8'h01, 8'h01, 8'h00, 8'hef, 8'h00, 8'h40, 8'h00};
  int          rise_cnt [2];
  int          total_rise [2];
  logic [31:0] cmd_cap [2];
  int          bad_mosi [2];
  int          bad_rise [2];
  int          en_cnt [2];
  int          done_cnt [2];
  int          cs_rise_cnt [2];
  logic [1:0]  fclk_prev = 2'b00;
  logic [1:0]  cs_prev   = 2'b11;
  int          bidx;
  logic [7:0]  cur_byte;
  logic [63:0] wr_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nb(input int i);
    return (i == 0) ? N0 : N1;
  endfunction

  function automatic logic [23:0] fa(input int i);
    return (i == 0) ? 24'h000000 : FA1;
  endfunction

  function automatic logic [31:0] rb(input int i);
    return (i == 0) ? 32'h0 : RB1;
  endfunction

  // ---------------- flash model and ramio monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fclk[i] && !fclk_prev[i]) begin
        if (cs_n[i]) begin
          bad_rise[i]++;
        end else begin
          if (rise_cnt[i] < 32) cmd_cap[i] = {cmd_cap[i][30:0], mosi[i]};
          else if (mosi[i] !== 1'b0) bad_mosi[i]++;
          rise_cnt[i]++;
          total_rise[i]++;
        end
      end
      // Flash shifts the next data bit out on each falling SPI clock after the address.
      if (!fclk[i] && fclk_prev[i] && !cs_n[i] && rise_cnt[i] >= 32) begin
        bidx = rise_cnt[i] - 32;
        if (bidx / 8 < 16) begin
          cur_byte = fmem[i][bidx / 8];
          miso[i]  = cur_byte[7 - (bidx % 8)];
        end else begin
          miso[i] = 1'b0;
        end
      end
      if (cs_n[i] && !cs_prev[i]) cs_rise_cnt[i]++;
      if (cs_n[i]) rise_cnt[i] = 0;
      if (en[i]) begin
        en_cnt[i]++;
        check("wr_type", wtype[i], RamWriteWord);
        check("rd_type", rtype[i], RamReadNone);
        if (i == 0 && exp_q0.size() > 0) begin
          wr_exp = exp_q0.pop_front();
          check("wr_addr0", raddr[i], wr_exp[63:32]);
          check("wr_data0", rdata[i], wr_exp[31:0]);
        end else if (i == 1 && exp_q1.size() > 0) begin
          wr_exp = exp_q1.pop_front();
          check("wr_addr1", raddr[i], wr_exp[63:32]);
          check("wr_data1", rdata[i], wr_exp[31:0]);
        end else begin
          check("wr_unexpected", raddr[i], 64'hFFFF_FFFF_FFFF_FFFF);
        end
      end
      if (done[i]) begin
        done_cnt[i]++;
        check("done_busy_low", busy[i], 0);
        check("done_cs_high", cs_n[i], 1);
      end
      fclk_prev[i] = fclk[i];
      cs_prev[i]   = cs_n[i];
    end
  end

  // ---------------- driver / model tasks ----------------
  task automatic clear_model(input int i);
    rise_cnt[i]    = 0;
    total_rise[i]  = 0;
    cmd_cap[i]     = 32'h0;
    bad_mosi[i]    = 0;
    bad_rise[i]    = 0;
    en_cnt[i]      = 0;
    done_cnt[i]    = 0;
    cs_rise_cnt[i] = 0;
    if (i == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic fill_fixed(input int i);
    for (int k = 0; k < 16; k++) fmem[i][k] = (k < 8) ? fixed_bytes[k] : 8'h00;
  endtask

  task automatic fill_random(input int i);
    for (int k = 0; k < 16; k++) fmem[i][k] = 8'($urandom_range(0, 255));
  endtask

  // Reference: bytes packed little-endian, missing tail bytes zero, +4 per word.
  task automatic build_exp(input int i);
    int n;
    logic [31:0] word;
    n = nb(i);
    for (int w = 0; w < (n + 3) / 4; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) word = word | (32'(fmem[i][4 * w + k]) << (8 * k));
      end
      if (i == 0) exp_q0.push_back({rb(i) + 32'(4 * w), word});
      else        exp_q1.push_back({rb(i) + 32'(4 * w), word});
    end
  endtask

  task automatic start_pulse(input int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy[i], 1);
    if (i == 0) begin
      check("cs_fall_no_wait", cs_n[i], 0);
    end else begin
      repeat (W1 - 1) @(posedge clk);
      @(negedge clk);
      check("cs_still_high_wait", cs_n[i], 1);
      @(posedge clk);
      @(negedge clk);
      check("cs_fall_after_wait", cs_n[i], 0);
    end
  endtask

  task automatic wait_rises(input int i, input int target);
    int cyc = 0;
    while (total_rise[i] < target && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    check("rise_wait", total_rise[i] >= target, 1);
  endtask

  task automatic wait_done(input int i, input bit random_busy);
    int cyc = 0;
    while (done_cnt[i] == 0 && cyc < 5000) begin
      @(posedge clk);
      #1;
      if (random_busy) begin
        rbusy[i] = ($urandom_range(0, 2) == 0);
        start[i] = ($urandom_range(0, 7) == 0);
      end
      cyc++;
    end
    rbusy[i] = 1'b0;
    start[i] = 1'b0;
    check("done_seen", done_cnt[i] > 0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic post_checks(input int i);
    int qs;
    qs = (i == 0) ? exp_q0.size() : exp_q1.size();
    check("done_once", done_cnt[i], 1);
    check("enable_count", en_cnt[i], (nb(i) + 3) / 4);
    check("writes_left", qs, 0);
    check("cmd_addr_bits", cmd_cap[i], {FlashCmdRead, fa(i)});
    check("spi_rises", total_rise[i], 32 + 8 * nb(i));
    check("mosi_zero_in_read", bad_mosi[i], 0);
    check("sclk_with_cs_high", bad_rise[i], 0);
    check("cs_rise_once", cs_rise_cnt[i], 1);
    check("cs_idle", cs_n[i], 1);
    check("busy_idle", busy[i], 0);
  endtask

  task automatic full_run(input int i, input bit use_fixed, input bit random_busy);
    clear_model(i);
    if (use_fixed) fill_fixed(i);
    else           fill_random(i);
    build_exp(i);
    start_pulse(i);
    wait_done(i, random_busy);
    post_checks(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_cs_n"},  cs_n[i], 1);
      check({tag, "_fclk"},  fclk[i], 0);
      check({tag, "_mosi"},  mosi[i], 0);
      check({tag, "_busy"},  busy[i], 0);
      check({tag, "_done"},  done[i], 0);
      check({tag, "_en"},    en[i], 0);
      check({tag, "_wtype"}, wtype[i], RamWriteNone);
      check({tag, "_rtype"}, rtype[i], RamReadNone);
      check({tag, "_addr"},  raddr[i], 0);
      check({tag, "_data"},  rdata[i], 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_model(0);
    clear_model(1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Reset pulse while idle.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_idle");
    @(posedge clk); #1 rst = 1'b0;

    // Known image, 8 bytes, free-running ramio.
    full_run(0, 1'b1, 1'b0);

    // Hold ramio busy over the first write: stream must stall with no enable.
    clear_model(0);
    fill_fixed(0);
    build_exp(0);
    rbusy[0] = 1'b1;
    start_pulse(0);
    wait_rises(0, 64);
    repeat (2) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_enable", en[0], 0);
      check("stall_fclk", fclk[0], 0);
    end
    @(posedge clk); #1 rbusy[0] = 1'b0;
    wait_done(0, 1'b0);
    post_checks(0);

    // Six-byte image: partial final word, startup wait, offset addresses.
    full_run(1, 1'b1, 1'b0);

    // Random images with random ramio back-pressure and stray start pulses.
    for (int r = 0; r < 3; r++) begin
      full_run(0, 1'b0, 1'b1);
      full_run(1, 1'b0, 1'b1);
    end

    // Reset in the middle of the data phase, then a clean rerun.
    clear_model(0);
    fill_random(0);
    start_pulse(0);
    wait_rises(0, 40);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_read_cs_n", cs_n[0], 1);
    check("rst_read_fclk", fclk[0], 0);
    check("rst_read_busy", busy[0], 0);
    @(posedge clk); #1 rst = 1'b0;
    full_run(0, 1'b1, 1'b0);

    // Reset after writes: address/data registers must clear too.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_final");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
